// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and FSM state encoding for the PS/2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_E0   = 8'hE0;
  localparam logic [7:0] PS2_F0   = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERRF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    E0   = 2'd1,
    F0   = 2'd2,
    E0F0 = 2'd3
  } ps2_state_t;

  // 00 and FF are keyboard error/overrun codes and never valid scan codes
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERRF);
  endfunction

endpackage

// File: rtl/ps2_held_table.sv
// ps2_held_table: small table of currently held keys, each entry {ext,code}.
// Lookup is combinational; insert/remove take effect on the next clock edge.
module ps2_held_table #(
  parameter int HELD_N = 4,
  localparam int HC_W  = $clog2(HELD_N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [8:0]      key,
  input  logic            insert,
  input  logic            remove,
  output logic            hit,
  output logic            full,
  output logic [HC_W-1:0] count
);

  localparam int IDX_W = (HELD_N > 1) ? $clog2(HELD_N) : 1;

  logic [HELD_N-1:0] valid;
  logic [8:0]        keys [HELD_N];
  logic [IDX_W-1:0]  hit_idx;
  logic [IDX_W-1:0]  free_idx;

  // Lookup, lowest free slot and occupancy; scanning downwards lets the lowest index win
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    count    = '0;
    for (int i = HELD_N - 1; i >= 0; i--) begin
      if (valid[i] && keys[i] == key) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_idx = IDX_W'(i);
      end
      count = count + HC_W'(valid[i]);
    end
  end

  assign full = &valid;

  // Single-cycle table update; a new key is stored only if it is absent and a slot is free
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (insert && !hit && !full) begin
        valid[free_idx] <= 1'b1;
        keys[free_idx]  <= key;
      end
      if (remove && hit) begin
        valid[hit_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops bytes from the ps2_keyboard FIFO, parses set-2 make/break/E0
// sequences into one-cycle key events and tracks held keys and a wrapping press count.
// Optional macro PS2_REPEAT_FILTER_EN suppresses typematic repeats of already-held keys.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int  CNT_W  = 8,
  parameter int  HELD_N = 4,
  localparam int HC_W   = $clog2(HELD_N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_err,
  output logic [CNT_W-1:0] press_cnt,
  output logic [HC_W-1:0]  held_cnt,
  output logic             any_held,
  output logic [7:0]       last_code,
  output logic             ovf_seen
);

  ps2_state_t state;
  ps2_state_t nxt_state;
  logic       consume;
  logic       do_make;
  logic       do_break;
  logic       do_err;
  logic       key_ext;
  logic       emit_make;
  logic       table_hit;
  logic       table_full;

  assign consume    = ready & ~rst;
  assign nextdata_n = ~consume;

  // Classify the FIFO head byte against the current prefix state
  always_comb begin
    nxt_state = state;
    do_make   = 1'b0;
    do_break  = 1'b0;
    do_err    = 1'b0;
    key_ext   = 1'b0;
    if (is_err_byte(data)) begin
      do_err    = 1'b1;
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (data == PS2_E0) begin
            nxt_state = E0;
          end else if (data == PS2_F0) begin
            nxt_state = F0;
          end else begin
            do_make = 1'b1;
          end
        end
        E0: begin
          if (data == PS2_F0) begin
            nxt_state = E0F0;
          end else if (data == PS2_E0) begin
            nxt_state = E0;
          end else begin
            do_make   = 1'b1;
            key_ext   = 1'b1;
            nxt_state = IDLE;
          end
        end
        F0, E0F0: begin
          if (data == PS2_F0) begin
            do_err    = 1'b1;
            nxt_state = F0;
          end else if (data == PS2_E0) begin
            do_err    = 1'b1;
            nxt_state = E0;
          end else begin
            do_break  = 1'b1;
            key_ext   = (state == E0F0);
            nxt_state = IDLE;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  assign emit_make = do_make & ~table_hit;
`else
  assign emit_make = do_make;
`endif

  ps2_held_table #(
    .HELD_N(HELD_N)
  ) u_held_table (
    .clk    (clk),
    .rst    (rst),
    .key    ({key_ext, data}),
    .insert (consume & do_make & ~table_hit & ~table_full),
    .remove (consume & do_break),
    .hit    (table_hit),
    .full   (table_full),
    .count  (held_cnt)
  );

  assign any_held = (held_cnt != '0);

  // Prefix FSM with registered event strobes, event fields, counters and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ev_valid  <= 1'b0;
      ev_err    <= 1'b0;
      ev_code   <= '0;
      ev_ext    <= 1'b0;
      ev_break  <= 1'b0;
      press_cnt <= '0;
      last_code <= '0;
      ovf_seen  <= 1'b0;
    end else begin
      ev_valid <= 1'b0;
      ev_err   <= 1'b0;
      if (overflow) begin
        ovf_seen <= 1'b1;
      end
      if (consume) begin
        state <= nxt_state;
        if (do_err) begin
          ev_err <= 1'b1;
        end
        if (emit_make || do_break) begin
          ev_valid <= 1'b1;
          ev_code  <= data;
          ev_ext   <= key_ext;
          ev_break <= do_break;
        end
        if (emit_make) begin
          press_cnt <= press_cnt + CNT_W'(1);
          last_code <= data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed self-checking bench for ps2_key_decoder (HELD_N=4, CNT_W=3).
module tb_ps2_key_decoder;

  logic       clk;
  logic       rst;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_err;
  logic [2:0] press_cnt;
  logic [2:0] held_cnt;
  logic       any_held;
  logic [7:0] last_code;
  logic       ovf_seen;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  ps2_key_decoder #(
    .CNT_W  (3),
    .HELD_N (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .data       (data),
    .overflow   (overflow),
    .nextdata_n (nextdata_n),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .ev_err     (ev_err),
    .press_cnt  (press_cnt),
    .held_cnt   (held_cnt),
    .any_held   (any_held),
    .last_code  (last_code),
    .ovf_seen   (ovf_seen)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for exactly one clock edge, then sample just after that edge
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    ready = 1'b1;
    data  = b;
    #1;
    checkOutput("pop strobe", {31'd0, nextdata_n}, 32'd0);
    if (nextdata_n == 1'b0) pops++;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst   = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    pops = 0;
  endtask

  task automatic checkEvent(input string tag, input logic v, input logic e,
                            input logic [7:0] code, input logic ext, input logic brk,
                            input int pc, input int hc);
    checkOutput({tag, " ev_valid"}, {31'd0, ev_valid}, {31'd0, v});
    checkOutput({tag, " ev_err"}, {31'd0, ev_err}, {31'd0, e});
    if (v) begin
      checkOutput({tag, " ev_code"}, {24'd0, ev_code}, {24'd0, code});
      checkOutput({tag, " ev_ext"}, {31'd0, ev_ext}, {31'd0, ext});
      checkOutput({tag, " ev_break"}, {31'd0, ev_break}, {31'd0, brk});
    end
    checkOutput({tag, " press_cnt"}, {29'd0, press_cnt}, pc);
    checkOutput({tag, " held_cnt"}, {29'd0, held_cnt}, hc);
    checkOutput({tag, " any_held"}, {31'd0, any_held}, {31'd0, (hc != 0)});
  endtask

  logic [7:0] pairs [9] = '{8'h24, 8'h25, 8'h26, 8'h2B, 8'h2C, 8'h2D, 8'h2E, 8'h32, 8'h33};

  initial begin
    int pc;
    rst      = 1'b1;
    ready    = 1'b1;
    data     = 8'h1C;
    overflow = 1'b0;
    #1;
    checkOutput("pop blocked in reset", {31'd0, nextdata_n}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    checkEvent("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0);
    checkOutput("reset last_code", {24'd0, last_code}, 32'd0);
    checkOutput("reset ovf_seen", {31'd0, ovf_seen}, 32'd0);
    checkOutput("reset ev_code", {24'd0, ev_code}, 32'd0);
    @(negedge clk);
    ready = 1'b0;
    rst   = 1'b0;
    pops  = 0;

    // 1: plain make then break
    applyStimulus(8'h1C); checkEvent("t1 make", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 1, 1);
    applyStimulus(8'hF0); checkEvent("t1 f0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1);
    checkOutput("t1 code hold", {24'd0, ev_code}, 32'h1C);
    applyStimulus(8'h1C); checkEvent("t1 break", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b1, 1, 0);
    checkOutput("t1 pops", pops, 3);
    checkOutput("t1 last_code", {24'd0, last_code}, 32'h1C);

    // 2: extended make and break
    doReset();
    applyStimulus(8'hE0); checkEvent("t2 e0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0);
    applyStimulus(8'h75); checkEvent("t2 make", 1'b1, 1'b0, 8'h75, 1'b1, 1'b0, 1, 1);
    applyStimulus(8'hE0); checkEvent("t2 e0b", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1);
    applyStimulus(8'hF0); checkEvent("t2 f0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1);
    applyStimulus(8'h75); checkEvent("t2 break", 1'b1, 1'b0, 8'h75, 1'b1, 1'b1, 1, 0);
    checkOutput("t2 last_code", {24'd0, last_code}, 32'h75);

    // 3: typematic repeat
    doReset();
`ifdef PS2_REPEAT_FILTER_EN
    applyStimulus(8'h1C); checkEvent("t3 rep1", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 1, 1);
    applyStimulus(8'h1C); checkEvent("t3 rep2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1);
    applyStimulus(8'h1C); checkEvent("t3 rep3", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C); checkEvent("t3 break", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b1, 1, 0);
`else
    applyStimulus(8'h1C); checkEvent("t3 rep1", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 1, 1);
    applyStimulus(8'h1C); checkEvent("t3 rep2", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 2, 1);
    applyStimulus(8'h1C); checkEvent("t3 rep3", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 3, 1);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C); checkEvent("t3 break", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b1, 3, 0);
`endif

    // 4: table full and press counter wrap
    doReset();
    applyStimulus(8'h15); checkEvent("t4 m15", 1'b1, 1'b0, 8'h15, 1'b0, 1'b0, 1, 1);
    applyStimulus(8'h16); checkEvent("t4 m16", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 2, 2);
    applyStimulus(8'h1C); checkEvent("t4 m1C", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 3, 3);
    applyStimulus(8'h1D); checkEvent("t4 m1D", 1'b1, 1'b0, 8'h1D, 1'b0, 1'b0, 4, 4);
    applyStimulus(8'h23); checkEvent("t4 m23 full", 1'b1, 1'b0, 8'h23, 1'b0, 1'b0, 5, 4);
    checkOutput("t4 last_code", {24'd0, last_code}, 32'h23);
    pc = 5;
    for (int i = 0; i < 9; i++) begin
      pc = (pc + 1) % 8;
      applyStimulus(pairs[i]); checkEvent("t4 pair make", 1'b1, 1'b0, pairs[i], 1'b0, 1'b0, pc, 4);
      applyStimulus(8'hF0);
      applyStimulus(pairs[i]); checkEvent("t4 pair break", 1'b1, 1'b0, pairs[i], 1'b0, 1'b1, pc, 4);
      if (i == 2) checkOutput("t4 wrap", {29'd0, press_cnt}, 32'd0);
    end
    applyStimulus(8'hF0);
    applyStimulus(8'h15); checkEvent("t4 free slot", 1'b1, 1'b0, 8'h15, 1'b0, 1'b1, 6, 3);
    applyStimulus(8'h15); checkEvent("t4 reinsert", 1'b1, 1'b0, 8'h15, 1'b0, 1'b0, 7, 4);

    // 5: protocol errors and resynchronisation
    doReset();
    applyStimulus(8'hF0); checkEvent("t5 f0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0);
    applyStimulus(8'hF0); checkEvent("t5 f0f0 err", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0, 0);
    applyStimulus(8'h1C); checkEvent("t5 break", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b1, 0, 0);
    applyStimulus(8'h00); checkEvent("t5 00 err", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0, 0);
    checkOutput("t5 code hold", {24'd0, ev_code}, 32'h1C);
    checkOutput("t5 break hold", {31'd0, ev_break}, 32'd1);
    applyStimulus(8'h1C); checkEvent("t5 idle make", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 1, 1);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'hF0); checkEvent("t5 e0f0f0 err", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1, 1);
    applyStimulus(8'h1C); checkEvent("t5 resync break", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b1, 1, 0);
    applyStimulus(8'hE0);
    applyStimulus(8'hE0); checkEvent("t5 e0e0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0);
    applyStimulus(8'h75); checkEvent("t5 e0e0 make", 1'b1, 1'b0, 8'h75, 1'b1, 1'b0, 2, 1);
    applyStimulus(8'hE0);
    applyStimulus(8'hFF); checkEvent("t5 e0 ff err", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2, 1);
    applyStimulus(8'h5A); checkEvent("t5 after ff", 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 3, 2);

    // 6: overflow flag and reset mid-sequence
    doReset();
    @(negedge clk); overflow = 1'b1;
    @(negedge clk); overflow = 1'b0;
    checkOutput("t6 ovf set", {31'd0, ovf_seen}, 32'd1);
    applyStimulus(8'h1C); checkEvent("t6 make", 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 1, 1);
    checkOutput("t6 ovf sticky", {31'd0, ovf_seen}, 32'd1);
    applyStimulus(8'hE0);
    @(negedge clk);
    rst   = 1'b1;
    ready = 1'b1;
    data  = 8'h75;
    #1;
    checkOutput("t6 pop in reset", {31'd0, nextdata_n}, 32'd1);
    @(posedge clk);
    #1;
    checkEvent("t6 in reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0);
    checkOutput("t6 ovf cleared", {31'd0, ovf_seen}, 32'd0);
    checkOutput("t6 last_code cleared", {24'd0, last_code}, 32'd0);
    checkOutput("t6 ev_code cleared", {24'd0, ev_code}, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ready = 1'b0;
    applyStimulus(8'h75); checkEvent("t6 after reset", 1'b1, 1'b0, 8'h75, 1'b0, 1'b0, 1, 1);
    checkOutput("t6 ovf stays clear", {31'd0, ovf_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Parametrised scan-code decoder between the `ps2_keyboard` FIFO (`ready`/`data`/`nextdata_n`) and display/CPU logic.
- Pops every byte the keyboard FIFO presents.
- Parses set-2 make, break (F0) and extended (E0) sequences.
- Emits one-cycle key events.
- Keeps a table of currently held keys and a wrapping press counter.

Parameters:
- CNT_W, 8: width of the press counter; wraps modulo 2^CNT_W.
- HELD_N, 4: number of entries in the held-key table (at least 1).
- HC_W, $clog2(HELD_N+1): width of `held_cnt` (local parameter).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ready  in  1  keyboard FIFO non-empty; `data` is valid
- data  in  8  FIFO head byte
- overflow  in  1  keyboard FIFO overflow flag
- nextdata_n  out  1  active-low pop strobe to keyboard FIFO
- ev_valid  out  1  one-cycle key event strobe
- ev_code  out  8  event scan code (prefixes stripped)
- ev_ext  out  1  event had E0 prefix
- ev_break  out  1  1 = release, 0 = press
- ev_err  out  1  one-cycle protocol-error strobe
- press_cnt  out  CNT_W  count of accepted make events
- held_cnt  out  HC_W  number of valid held-table entries
- any_held  out  1  held_cnt != 0
- last_code  out  8  code of the most recent make event
- ovf_seen  out  1  sticky; set when `overflow` is sampled high

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous, active-high.
- Reset values: every registered output is 0, the FSM is in IDLE and the table is emptied. `nextdata_n` is 1 while `rst` is high. A reset mid-sequence discards any pending E0/F0.
- Pop handshake:
  - `nextdata_n = ~(ready & ~rst)`, combinational.
  - A byte is consumed in every cycle with `ready`=1, so throughput is at most 1 byte/clk.
  - The consumed byte is processed on that same edge.
- Event latency: `ev_valid`, `ev_err`, `ev_*` fields and counters update on the edge that consumes the completing byte; they are visible 1 cycle later.
- `ev_valid` and `ev_err` are 1-cycle pulses and are never high together. `ev_code`, `ev_ext` and `ev_break` hold their value until the next event.
- FSM states: IDLE, E0, F0, E0F0.
  - IDLE:
    - E0 goes to E0; F0 goes to F0.
    - 00 or FF raises `ev_err` and stays in IDLE.
    - Any other byte is a make with ext=0.
  - E0:
    - F0 goes to E0F0.
    - E0 stays in E0 (no error).
    - Any other byte is a make with ext=1, then IDLE.
  - F0:
    - A code byte is a break with ext=0, then IDLE.
    - F0 raises `ev_err` and stays in F0.
    - E0 raises `ev_err` and goes to E0.
  - E0F0: a code byte is a break with ext=1, then IDLE. E0 or F0 raises `ev_err` and resynchronises as in F0.
  - From E0, F0 or E0F0, 00 or FF raises `ev_err` and returns to IDLE.
- Make:
  - If {ext,code} is not in the table, insert it in the lowest free slot, emit the event and increment `press_cnt` (wrapping).
  - If the table is full, the key is not stored, but the event is emitted and counted.
  - If the key is already present (typematic repeat), see Optional Feature.
  - `last_code` is updated on every emitted make.
- Break: clear the matching entry and emit the event. A break with no matching entry is still emitted; the table is unchanged.
- Overflow: `ovf_seen` is set on any cycle with `overflow`=1 and is cleared only by `rst`. The decoder keeps running.

Optional Feature:
- Macro: `PS2_REPEAT_FILTER_EN`.
- Defined: a make for a key already in the table produces no `ev_valid`, no `press_cnt` increment and no `last_code` update.
- Undefined: repeat makes are emitted and counted normally; the table is unchanged.

Decomposition:
- Package `ps2_pkg` holds:
  - constants PS2_E0=8'hE0, PS2_F0=8'hF0, PS2_ERR0=8'h00 and PS2_ERRF=8'hFF;
  - the FSM state encoding (2-bit).
- Sub-module `ps2_held_table` (parameter HELD_N) provides:
  - insert, remove and lookup of {ext,code};
  - hit, full and count outputs;
  - single-cycle update.

Test Plan:
1. Feed 1C, F0, 1C with back-to-back `ready`.
   - Required: make event 1C, ext=0, then break event 1C; 3 pops.
   - `press_cnt`=1; `held_cnt` goes 1 then 0.
2. Feed E0 75, E0 F0 75.
   - Required: make 75 with ext=1, then break 75 with ext=1; `last_code`=75.
3. Feed 1C ×3, then F0 1C.
   - Macro undefined: 3 make events, `press_cnt`=3, `held_cnt`=1 throughout, then 0.
   - Macro defined: 1 make event, `press_cnt`=1.
4. With HELD_N=4, CNT_W=3, make 15 16 1C 1D 23, then 9 further distinct make/break pairs.
   - Required: 5th make emitted while `held_cnt` stays 4.
   - `press_cnt` wraps 7 to 0.
5. Feed F0 F0 1C, then 00.
   - Required: one `ev_err` on the second F0, then break 1C.
   - Then `ev_err` on 00 with the FSM back in IDLE.
6. Feed E0, assert `rst` one cycle, then feed 75; separately pulse `overflow`.
   - Required: make 75 with ext=0 after reset; outputs 0 during reset; `ovf_seen`=1 until the next reset.
